// File: rtl/async_fifo_rd_ctrl.sv
// Read side of the dual-clock FIFO: owns the read pointer, issues RAM reads and
// presents first-word-fall-through data from a 2-entry buffer on a valid/ready port.
module async_fifo_rd_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    input  logic [DATASIZE-1:0] rmem_data,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rempty,
    output logic [ADDRSIZE+1:0] rlevel
);

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [ADDRSIZE:0]   rbin, rbin_nxt, wbin_sync, rdiff;
    logic                ren_d, mem_empty, pop;
    logic [1:0]          entries;
    logic [2:0]          occ_nxt;
    logic [DATASIZE-1:0] buf0, buf1;

    assign mem_empty = (rptr == rq2_wptr);
    assign pop       = rvalid & rready;
    // Occupancy the buffer will have after this edge, counting the word in flight.
    assign occ_nxt   = {1'b0, entries} + {2'b00, ren_d} - {2'b00, pop};
    // Gated by reset so no read is requested while the block is held in reset.
    assign ren       = rrst_n && !mem_empty && (occ_nxt < 3'd2);
    assign rbin_nxt  = rbin + {{ADDRSIZE{1'b0}}, ren};
    assign raddr     = rbin[ADDRSIZE-1:0];
    assign wbin_sync = gray2bin(rq2_wptr);
    assign rdiff     = wbin_sync - rbin;

    assign rdata  = buf0;
    assign rvalid = (entries != 2'd0);
    assign rempty = !rvalid;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin  <= '0;
            rptr  <= '0;
            ren_d <= 1'b0;
        end else begin
            rbin  <= rbin_nxt;
            rptr  <= rbin_nxt ^ (rbin_nxt >> 1);
            ren_d <= ren;
        end
    end

    // buf0 is always the head; a capture lands behind whatever survives the pop.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            buf0    <= '0;
            buf1    <= '0;
            entries <= 2'd0;
        end else begin
            case ({ren_d, pop})
                2'b10: begin
                    if (entries == 2'd0) buf0 <= rmem_data;
                    else                 buf1 <= rmem_data;
                    entries <= entries + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    entries <= entries - 2'd1;
                end
                2'b11: begin
                    if (entries == 2'd1) begin
                        buf0 <= rmem_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rmem_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rlevel <= '0;
        else         rlevel <= {1'b0, rdiff} + {{ADDRSIZE{1'b0}}, entries}
                             + {{(ADDRSIZE+1){1'b0}}, ren_d};
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-side controller for the dual-clock FIFO, entirely in the rclk domain.
- Consumes the synchronised Gray write pointer from the write-to-read synchroniser and owns the binary/Gray read pointer.
- Schedules synchronous reads from the dual-port RAM and presents first-word-fall-through data on a valid/ready interface, backed by a 2-entry output buffer.
- Its Gray read pointer feeds the read-to-write synchroniser for the write-side full logic.

Parameters:
- ADDRSIZE, 4: RAM address width; FIFO RAM depth is 2^ADDRSIZE.
- DATASIZE, 8: data word width.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset; asynchronous assert, active-low.
- rq2_wptr  in  ADDRSIZE+1  synchronised Gray write pointer.
- rptr  out  ADDRSIZE+1  registered Gray read pointer, to the read-to-write synchroniser.
- raddr  out  ADDRSIZE  RAM read address.
- ren  out  1  RAM read enable.
- rmem_data  in  DATASIZE  RAM read data, valid the cycle after ren.
- rdata  out  DATASIZE  head-of-FIFO data.
- rvalid  out  1  rdata valid.
- rready  in  1  consumer accepts rdata.
- rempty  out  1  equals !rvalid.
- rlevel  out  ADDRSIZE+2  registered word count visible to the reader.

Behaviour:
- Reset (rrst_n low, asynchronous): all of the following clear to 0 immediately, with no clock required:
  - rbin and rptr; raddr and ren are therefore 0.
  - ren_d, both buffer entries, rvalid, rdata and rlevel.
  - rempty reads 1.
- Reset mid-operation: buffered and in-flight words are discarded. The write side is reset jointly by system rule; no recovery of partial state.
- Pointers:
  - rbin is an ADDRSIZE+1 binary register; raddr = rbin[ADDRSIZE-1:0].
  - rptr = bin2gray(rbin), registered and updated on the same edge as rbin.
  - Both wrap modulo 2^(ADDRSIZE+1) naturally.
- mem_empty (combinational) = (rptr == rq2_wptr).
- pop = rvalid & rready.
- ren (combinational) = !mem_empty & ((entries + ren_d - pop) < 2), where entries is 0..2 and ren_d is the registered ren.
- On each edge with ren = 1: rbin increments by 1.
- On each edge with ren_d = 1: rmem_data is written into the buffer tail.
  - Capture and pop on the same edge: the FIFO ordering of the 2-entry buffer is preserved.
  - The buffer never overflows; the issue rule guarantees it.
- Buffer contents:
  - rdata = head entry; rvalid = (entries != 0).
  - rdata is held stable while rvalid & !rready.
  - rdata value when rvalid = 0 is don't-care; it resets to 0.
- Latency: the first ren is issued in the same cycle rq2_wptr first differs from rptr. rvalid rises after the second rclk edge counted from the start of that cycle.
- Throughput: 1 word/cycle sustained with rready held high. Steady state is entries = 1, ren_d = 1.
- Backpressure: with rready = 0, at most 2 words leave the RAM (entries = 2, ren = 0). rptr then stops, and the write side sees the space as still used only for unread RAM words.
- rlevel, registered every edge:
  - rlevel = ((gray2bin(rq2_wptr) - rbin) mod 2^(ADDRSIZE+1)) + entries + ren_d.
  - Maximum value is 2^ADDRSIZE + 2, hence ADDRSIZE+2 bits.
  - It lags the current state by one cycle.
- rq2_wptr may advance by more than one position between rclk edges; only the equality compare and the gray2bin conversion use it.
- rq2_wptr is never registered again here; it is already synchronised.

Test Plan:
- Reset: hold rrst_n = 0 with rq2_wptr = 5'b00011 -> rptr = 0, raddr = 0, ren = 0, rvalid = 0, rempty = 1, rlevel = 0. Release -> ren = 1 the first cycle.
- Single word (ADDRSIZE = 4):
  - Stimulus: rq2_wptr goes 0 -> 5'b00001; rmem_data = 8'hA5 in the cycle after ren; rready = 0.
  - Response: ren is high for exactly 1 cycle with raddr = 0. rptr = 5'b00001 after that edge. rvalid = 1 with rdata = A5 after the next edge, and is held. rlevel = 1.
- Stream:
  - Stimulus: rq2_wptr = gray(16) = 5'b11000; RAM model returns 8'h10+addr; rready = 1.
  - Response: ren is high 16 consecutive cycles. rvalid is high 16 consecutive cycles with rdata 8'h10..8'h1F in order. rptr ends at 5'b11000; rempty then = 1.
- Backpressure:
  - Stimulus: 16 words available, rready = 0.
  - Response: exactly 2 ren pulses (raddr 0, 1). rdata is stable at word 0, rlevel = 16, rptr = gray(2).
  - Then rready = 1: the remaining words are delivered in order with no loss or duplicate, 1 per cycle.
- Wrap: stream 40 words in bursts across rbin wrap (31 -> 0) -> raddr sequence is continuous modulo 16, rptr passes 5'b10000 -> 5'b00000, data order is correct, and no spurious ren occurs when rptr == rq2_wptr.
- Reset mid-stream: with entries = 2 and ren_d = 1, assert rrst_n = 0 mid-cycle -> rvalid, rdata, rptr and rlevel go to 0 before the next rclk edge, and ren = 0 while reset is held.
